// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan sequencer slice.
//   IDX_W_DEF   : default index width (matches a 4x16 decoder select input)
//   DWELL_W_DEF : default dwell counter width
//   state_t     : sequencer FSM state encoding (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int IDX_W_DEF   = 4;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : scan_pkg

// File: rtl/dec_4x16.sv
// -----------------------------------------------------------------------------
// dec_4x16
// Downstream 4-to-16 one-hot decoder driven by the scan sequencer.
//   i_en  : decode enable; output is all-zero when low
//   i_sel : select index
//   o_dec : one-hot output, bit i_sel set when enabled
// -----------------------------------------------------------------------------
module dec_4x16 (
  input  logic        i_en,
  input  logic [3:0]  i_sel,
  output logic [15:0] o_dec
);

  // NOTE: the output gets a default before the conditional update, so every
  // path through the block assigns it and no latch is inferred.
  always_comb begin
    o_dec = '0;
    if (i_en) begin
      o_dec[i_sel] = 1'b1;
    end
  end

endmodule : dec_4x16

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Down-counter that tracks how many more accepted cycles the current index
// must be held. A load takes priority over counting; counting saturates at 0.
//   clk        : clock
//   rst        : asynchronous active-high reset (count cleared to 0)
//   i_load     : load i_load_val into the counter this cycle
//   i_load_val : value to load
//   i_en       : decrement enable (only effective while the count is nonzero)
//   o_zero     : count is zero
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int DWELL_W = scan_pkg::DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_zero
);

  logic [DWELL_W-1:0] r_cnt;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule : dwell_timer

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
// Steps an index from first_idx to last_idx (wrapping modulo 2^IDX_W),
// holding each index for dwell+1 cycles in which sel_ready is high.
// Optionally loops back to first_idx forever until stop.
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous active-high reset
//   start     : single-cycle request to begin a scan (honoured in IDLE only)
//   stop      : abort a running scan (goes to DONE next edge)
//   first_idx : first index of the scan
//   last_idx  : last index of the scan
//   dwell     : extra accepted cycles spent on each index
//   loop_en   : restart at first_idx after last_idx instead of finishing
//   sel_ready : downstream can accept the current index
//   sel_out   : current index (registered)
//   sel_valid : sel_out is meaningful (registered, high in RUN)
//   busy      : scan in progress (registered, high in RUN)
//   done      : single-cycle completion pulse (registered, high in DONE)
// -----------------------------------------------------------------------------
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int IDX_W   = IDX_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [IDX_W-1:0]   first_idx,
  input  logic [IDX_W-1:0]   last_idx,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop_en,
  input  logic               sel_ready,
  output logic [IDX_W-1:0]   sel_out,
  output logic               sel_valid,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_sel;
  logic [IDX_W-1:0]   r_first;
  logic [IDX_W-1:0]   r_last;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_loop;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  logic               w_zero;
  logic               w_start;
  logic               w_accept;
  logic               w_at_last;
  logic               w_load;
  logic [DWELL_W-1:0] w_load_val;

  // Timer control. A dwell reload happens on scan start (from the live input,
  // since the latched copy is not written yet) and on every index advance
  // (from the latched copy). stop suppresses both counting and reloading.
  always_comb begin
    w_start    = (r_state == IDLE) && start;
    w_accept   = (r_state == RUN) && !stop && sel_ready;
    w_at_last  = (r_sel == r_last);
    w_load     = w_start || (w_accept && w_zero && (!w_at_last || r_loop));
    w_load_val = w_start ? dwell : r_dwell;
  end

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_accept),
    .o_zero     (w_zero)
  );

  // NOTE: reset clears every register, including the latched scan
  // parameters, so the block leaves reset in a fully known state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_first <= '0;
      r_last  <= '0;
      r_dwell <= '0;
      r_loop  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_first <= first_idx;
            r_last  <= last_idx;
            r_dwell <= dwell;
            r_loop  <= loop_en;
            r_sel   <= first_idx;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end

        RUN: begin
          if (stop) begin
            // Abort wins over any advance; sel_out keeps its value.
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (sel_ready && w_zero) begin
            if (!w_at_last) begin
              r_sel <= r_sel + IDX_W'(1);  // wraps modulo 2^IDX_W
            end else if (r_loop) begin
              r_sel <= r_first;
            end else begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sel_out   = r_sel;
  assign sel_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule : scan_sequencer

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
// Scoreboard bench: each directed scenario pushes the expected per-cycle
// output (index presented, or done pulse with held index) into a queue; an
// independent monitor pops and compares on every cycle the DUT shows
// sel_valid or done. A 4x16 decoder on sel_out is checked for one-hot.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [3:0]  first_idx;
  logic [3:0]  last_idx;
  logic [7:0]  dwell;
  logic        loop_en;
  logic        sel_ready;
  logic [3:0]  sel_out;
  logic        sel_valid;
  logic        busy;
  logic        done;
  logic [15:0] dec_out;

  typedef struct packed {
    logic       is_done;
    logic [3:0] sel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  scan_sequencer #(
    .IDX_W   (4),
    .DWELL_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .dwell     (dwell),
    .loop_en   (loop_en),
    .sel_ready (sel_ready),
    .sel_out   (sel_out),
    .sel_valid (sel_valid),
    .busy      (busy),
    .done      (done)
  );

  dec_4x16 u_dec (
    .i_en  (sel_valid),
    .i_sel (sel_out),
    .o_dec (dec_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_sel(input logic [3:0] v);
    exp_q.push_back('{is_done: 1'b0, sel: v});
  endtask

  task automatic push_done(input logic [3:0] v);
    exp_q.push_back('{is_done: 1'b1, sel: v});
  endtask

  // Issue a start at posedge+1; returns at posedge+1 of the first RUN cycle.
  // Inputs are scrambled afterwards so any use of unlatched values shows up.
  task automatic start_scan(input logic [3:0] f, input logic [3:0] l,
                            input logic [7:0] d, input logic lp);
    first_idx = f;
    last_idx  = l;
    dwell     = d;
    loop_en   = lp;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    first_idx = ~f;
    last_idx  = ~l;
    dwell     = d + 8'd3;
    loop_en   = ~lp;
  endtask

  // Wait (bounded) for the monitor to consume all expectations, then check
  // that the following cycle is idle.
  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check({name, "_idle_busy"}, busy, 1'b0);
    check({name, "_idle_valid"}, sel_valid, 1'b0);
    check({name, "_idle_done"}, done, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents an index or a done pulse, compare
  // with the next expected entry.
  always @(negedge clk) begin
    if (!rst && (sel_valid || done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {26'd0, done, sel_valid, sel_out}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_done) begin
          check("done_pulse", done, 1'b1);
          check("done_valid", sel_valid, 1'b0);
          check("done_busy", busy, 1'b0);
          check("done_sel_hold", sel_out, mon_e.sel);
        end else begin
          check("sel_out", sel_out, mon_e.sel);
          check("sel_valid", sel_valid, 1'b1);
          check("run_busy", busy, 1'b1);
          check("run_done", done, 1'b0);
          check("dec_onehot", dec_out, 16'h0001 << mon_e.sel);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    first_idx = 4'd0;
    last_idx  = 4'd0;
    dwell     = 8'd0;
    loop_en   = 1'b0;
    sel_ready = 1'b1;

    #1;
    check("reset_sel", sel_out, 4'd0);
    check("reset_valid", sel_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_dec", dec_out, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // 2..5, no dwell, always ready
    push_sel(4'd2); push_sel(4'd3); push_sel(4'd4); push_sel(4'd5);
    push_done(4'd5);
    start_scan(4'd2, 4'd5, 8'd0, 1'b0);
    wait_drain("basic", 20);

    // 14..1 through the wrap, dwell=1
    push_sel(4'd14); push_sel(4'd14); push_sel(4'd15); push_sel(4'd15);
    push_sel(4'd0);  push_sel(4'd0);  push_sel(4'd1);  push_sel(4'd1);
    push_done(4'd1);
    start_scan(4'd14, 4'd1, 8'd1, 1'b0);
    wait_drain("wrap", 30);

    // 3..4 with sel_ready low for 3 cycles while on index 3
    push_sel(4'd3); push_sel(4'd3); push_sel(4'd3); push_sel(4'd3);
    push_sel(4'd4);
    push_done(4'd4);
    sel_ready = 1'b0;
    start_scan(4'd3, 4'd4, 8'd0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    sel_ready = 1'b1;
    wait_drain("stall", 20);

    // single index, dwell=2
    push_sel(4'd9); push_sel(4'd9); push_sel(4'd9);
    push_done(4'd9);
    start_scan(4'd9, 4'd9, 8'd2, 1'b0);
    wait_drain("single", 20);

    // looping 0,1,... then stop
    push_sel(4'd0); push_sel(4'd1); push_sel(4'd0);
    push_sel(4'd1); push_sel(4'd0); push_sel(4'd1);
    push_done(4'd1);
    start_scan(4'd0, 4'd1, 8'd0, 1'b1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_drain("loop_stop", 20);

    // stop while sel_ready is low, mid-dwell
    push_sel(4'd8); push_sel(4'd8);
    push_done(4'd8);
    start_scan(4'd8, 4'd9, 8'd3, 1'b0);
    @(posedge clk);
    #1;
    sel_ready = 1'b0;
    stop      = 1'b1;
    @(posedge clk);
    #1;
    stop      = 1'b0;
    sel_ready = 1'b1;
    wait_drain("stop_stalled", 20);

    // start while busy is ignored; reset at index 7 aborts with no done
    push_sel(4'd5); push_sel(4'd6); push_sel(4'd7);
    start_scan(4'd5, 4'd10, 8'd0, 1'b0);
    start     = 1'b1;
    first_idx = 4'd12;
    last_idx  = 4'd13;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_drained", exp_q.size(), 0);
    check("midrst_sel", sel_out, 4'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", sel_valid, 1'b0);
    check("midrst_done", done, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("midrst_hold_done", done, 1'b0);

    // start honoured on the very first edge after reset release
    push_sel(4'd1); push_sel(4'd2);
    push_done(4'd2);
    @(negedge clk);
    #1 rst = 1'b0;
    start_scan(4'd1, 4'd2, 8'd0, 1'b0);
    wait_drain("post_reset", 20);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_scan_sequencer
